lut_neuron_pipe: RTL and testbench

Runtime-loadable, pipelined truth-table neuron for LogicNets-style layers. It replaces the fixed combinational per-neuron ROM with a parametrised 2^IN_BITS × OUT_BITS distributed table and a 2-stage registered lookup path with valid/ready flow control. A configuration port rewrites the table in-system: the block drains in-flight lookups first, then accepts writes, then resumes. It sits between a layer's input-bit gather logic and the next layer's gather logic, one instance per neuron.

---
 rtl/lut_neuron_pipe_if.sv | 34 +++
 rtl/lut_neuron_pipe.sv | 115 +++++++++++
 tb/tb_lut_neuron_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_neuron_pipe_if.sv
// lut_neuron_pipe_if
//   Bundles the lookup request channel (in_*), the result channel (out_*)
//   and the table configuration port (cfg_*) of one truth-table neuron.
//   slave  : the neuron side (drives in_ready, out_valid, out_data, cfg_ready)
//   master : the side feeding requests/configuration and consuming results
interface lut_neuron_pipe_if #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1
);
  logic                in_valid;
  logic                in_ready;
  logic [IN_BITS-1:0]  in_data;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] out_data;
  logic                cfg_start;
  logic                cfg_we;
  logic [IN_BITS-1:0]  cfg_addr;
  logic [OUT_BITS-1:0] cfg_data;
  logic                cfg_done;
  logic                cfg_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    input  cfg_start, cfg_we, cfg_addr, cfg_data, cfg_done,
    output in_ready, out_valid, out_data, cfg_ready
  );

  modport master (
    output in_valid, in_data, out_ready,
    output cfg_start, cfg_we, cfg_addr, cfg_data, cfg_done,
    input  in_ready, out_valid, out_data, cfg_ready
  );
endinterface

// File: rtl/lut_neuron_pipe.sv
// lut_neuron_pipe
//   Runtime-loadable truth-table neuron: a 2^IN_BITS x OUT_BITS distributed
//   table looked up through a two-stage registered pipeline with valid/ready
//   flow control. A reload request first drains lookups already in flight,
//   then opens the configuration port until cfg_done resumes lookups.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (control and output registers only;
//          table contents survive reset)
//   bus  : lut_neuron_pipe_if.slave
//          in_valid/in_ready/in_data     lookup request (index)
//          out_valid/out_ready/out_data  lookup result table[index]
//          cfg_start/cfg_done            reload request / reload complete
//          cfg_we/cfg_addr/cfg_data      table write, honoured while cfg_ready
//          cfg_ready                     high while the table is writable
module lut_neuron_pipe #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  lut_neuron_pipe_if.slave bus
);

  localparam int DEPTH = 1 << IN_BITS;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [OUT_BITS-1:0] lut_mem [DEPTH];

  logic                vld_p1;
  logic [IN_BITS-1:0]  addr_p1;
  logic                vld_p2;
  logic [OUT_BITS-1:0] data_p2;

  logic                advance;
  logic                in_rdy;
  logic                accept;

  // Stage 2 may move whenever it is empty or its result is being taken.
  assign advance = !vld_p2 || bus.out_ready;
  // Depends only on registered state and out_ready, never on in_valid.
  assign in_rdy  = (state == RUN) && (!vld_p1 || advance);
  assign accept  = bus.in_valid && in_rdy;

  assign bus.in_ready  = in_rdy;
  assign bus.cfg_ready = (state == LOAD);
  assign bus.out_valid = vld_p2;
  assign bus.out_data  = data_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (bus.cfg_done) state_nxt = RUN;
      RUN:     if (bus.cfg_start) state_nxt = DRAIN;
      DRAIN:   if (!vld_p1 && !vld_p2) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Table storage: written only while loading, never cleared.
  always_ff @(posedge clk) begin
    if ((state == LOAD) && bus.cfg_we) begin
      lut_mem[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // ---- stage 1: capture accepted index ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (advance) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1 <= bus.in_data;
    end
  end

  // ---- stage 2: asynchronous table read registered into the result ----
  // The result register is only overwritten by a real lookup so that it never
  // samples a not-yet-written table entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else if (advance) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= lut_mem[addr_p1];
      end
    end
  end

endmodule

// File: tb/tb_lut_neuron_pipe.sv
module tb_lut_neuron_pipe;

  localparam int IN_BITS  = 8;
  localparam int OUT_BITS = 1;

  logic clk;
  logic rst;

  lut_neuron_pipe_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) b ();

  lut_neuron_pipe #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: mode (0 load, 1 run, 2 drain), table image, and an
  // ordered list of results owed by lookups accepted but not yet delivered.
  int mstate = 0;
  bit [OUT_BITS-1:0] tbl [256];
  int exp_q[$];
  int want_q[$];
  int got_q[$];
  bit last_acc;

  function automatic bit m_in_ready();
    return (mstate == 1) && ((exp_q.size() < 2) || (b.out_ready == 1'b1));
  endfunction

  // Advance one clock: called at the falling edge with inputs already set.
  task automatic cycle();
    bit acc;
    bit del;
    bit empty_before;
    #1;
    acc = (b.in_valid == 1'b1) && m_in_ready();
    del = (b.out_valid === 1'b1) && (b.out_ready == 1'b1);
    empty_before = (exp_q.size() == 0);
    last_acc = acc;
    if (mstate == 0 && b.cfg_we == 1'b1) tbl[b.cfg_addr] = b.cfg_data;
    if (rst) begin
      mstate = 0;
      exp_q.delete();
      last_acc = 1'b0;
    end else begin
      if (del) begin
        got_q.push_back(int'(b.out_data));
        if (exp_q.size() > 0) want_q.push_back(exp_q.pop_front());
        else want_q.push_back(-1);
      end
      if (acc) exp_q.push_back(int'(tbl[b.in_data]));
      case (mstate)
        0: if (b.cfg_done == 1'b1) mstate = 1;
        1: if (b.cfg_start == 1'b1) mstate = 2;
        2: if (empty_before) mstate = 0;
        default: mstate = 0;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    b.in_valid  = 1'b0;
    b.in_data   = '0;
    b.cfg_start = 1'b0;
    b.cfg_we    = 1'b0;
    b.cfg_addr  = '0;
    b.cfg_data  = '0;
    b.cfg_done  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", b.out_valid); end
    checks++; if (b.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", b.out_data); end
    checks++; if (b.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", b.in_ready); end
    checks++; if (b.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %0b expected 1", b.cfg_ready); end
    rst = 1'b0;
  endtask

  task automatic test_load();
    b.out_ready = 1'b1;
    for (int a = 0; a < 256; a++) begin
      b.cfg_we   = 1'b1;
      b.cfg_addr = 8'(a);
      b.cfg_data = (a == 'h40 || a == 'h02) ? 1'b1 : 1'b0;
      #1;
      if (a == 0) begin
        checks++; if (b.in_ready !== 1'b0) begin errors++; $display("FAIL load_in_ready: got %0b expected 0", b.in_ready); end
      end
      cycle();
    end
    b.cfg_we   = 1'b0;
    b.cfg_done = 1'b1;
    cycle();
    b.cfg_done = 1'b0;
    #1;
    checks++; if (b.cfg_ready !== 1'b0) begin errors++; $display("FAIL load_done_cfg_ready: got %0b expected 0", b.cfg_ready); end
    checks++; if (b.in_ready !== 1'b1) begin errors++; $display("FAIL load_done_in_ready: got %0b expected 1", b.in_ready); end
  endtask

  task automatic test_stream();
    logic [7:0] seq [4];
    bit exp_v [6];
    int exp_d [6];
    logic ov;
    int od;
    seq[0] = 8'h40; seq[1] = 8'h00; seq[2] = 8'h02; seq[3] = 8'h80;
    exp_v[0] = 0; exp_v[1] = 1; exp_v[2] = 1; exp_v[3] = 1; exp_v[4] = 1; exp_v[5] = 0;
    exp_d[1] = 1; exp_d[2] = 0; exp_d[3] = 1; exp_d[4] = 0;
    b.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin b.in_valid = 1'b1; b.in_data = seq[k]; end
      else b.in_valid = 1'b0;
      cycle();
      ov = b.out_valid;
      od = int'(b.out_data);
      checks++; if (ov !== exp_v[k]) begin errors++; $display("FAIL stream_valid[%0d]: got %0b expected %0b", k, ov, exp_v[k]); end
      if (exp_v[k]) begin
        checks++; if (od != exp_d[k]) begin errors++; $display("FAIL stream_data[%0d]: got %0d expected %0d", k, od, exp_d[k]); end
      end
    end
    got_q.delete();
    want_q.delete();
  endtask

  task automatic test_backpressure();
    logic [7:0] items [6];
    int idx = 0;
    logic prev_v;
    int prev_d;
    bit stalled;
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0: items[i] = 8'h40;
        1: items[i] = 8'h02;
        default: items[i] = 8'($urandom_range(0, 255));
      endcase
    end
    prev_v = b.out_valid;
    prev_d = int'(b.out_data);
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (idx == 6 && exp_q.size() == 0) break;
      b.out_ready = (cyc >= 2 && cyc < 7) ? 1'b0 : 1'b1;
      if (idx < 6) begin b.in_valid = 1'b1; b.in_data = items[idx]; end
      else b.in_valid = 1'b0;
      #1;
      checks++; if (b.in_ready !== m_in_ready()) begin errors++; $display("FAIL bp_in_ready[%0d]: got %0b expected %0b", cyc, b.in_ready, m_in_ready()); end
      if (cyc == 6) begin
        checks++; if (b.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready: got %0b expected 0", b.in_ready); end
      end
      stalled = (b.out_ready == 1'b0) && (prev_v == 1'b1);
      cycle();
      if (last_acc) idx++;
      if (stalled) begin
        checks++; if (b.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %0b expected 1", cyc, b.out_valid); end
        checks++; if (int'(b.out_data) != prev_d) begin errors++; $display("FAIL bp_hold_data[%0d]: got %0d expected %0d", cyc, b.out_data, prev_d); end
      end
      prev_v = b.out_valid;
      prev_d = int'(b.out_data);
    end
    b.in_valid = 1'b0;
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < want_q.size(); i++) begin
      checks++; if (got_q[i] != want_q[i]) begin errors++; $display("FAIL bp_order[%0d]: got %0d expected %0d", i, got_q[i], want_q[i]); end
    end
    got_q.delete();
    want_q.delete();
  endtask

  task automatic test_reload();
    int n;
    b.out_ready = 1'b0;
    b.in_valid = 1'b1; b.in_data = 8'h40; cycle();
    b.in_data = 8'h02; cycle();
    b.in_valid = 1'b0;
    b.cfg_start = 1'b1; cycle();
    b.cfg_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (b.in_ready !== 1'b0) begin errors++; $display("FAIL reload_in_ready[%0d]: got %0b expected 0", i, b.in_ready); end
      checks++; if (b.cfg_ready !== 1'b0) begin errors++; $display("FAIL reload_cfg_ready[%0d]: got %0b expected 0", i, b.cfg_ready); end
      checks++; if (b.out_valid !== 1'b1) begin errors++; $display("FAIL reload_out_valid[%0d]: got %0b expected 1", i, b.out_valid); end
      cycle();
    end
    b.out_ready = 1'b1;
    n = 0;
    while (b.cfg_ready !== 1'b1 && n < 10) begin cycle(); n++; end
    checks++; if (b.cfg_ready !== 1'b1) begin errors++; $display("FAIL reload_drain_timeout: cfg_ready got %0b expected 1", b.cfg_ready); end
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL reload_delivered: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] != 1) begin errors++; $display("FAIL reload_result[%0d]: got %0d expected 1", i, got_q[i]); end
    end
    got_q.delete();
    want_q.delete();
    b.cfg_we = 1'b1; b.cfg_addr = 8'h40; b.cfg_data = 1'b0; cycle();
    b.cfg_we = 1'b0; b.cfg_done = 1'b1; cycle();
    b.cfg_done = 1'b0;
    b.in_valid = 1'b1; b.in_data = 8'h40; cycle();
    b.in_valid = 1'b0; cycle();
    checks++; if (b.out_valid !== 1'b1) begin errors++; $display("FAIL reload_lookup_valid: got %0b expected 1", b.out_valid); end
    checks++; if (b.out_data !== 1'b0) begin errors++; $display("FAIL reload_lookup_data: got %0d expected 0", b.out_data); end
    cycle();
    got_q.delete();
    want_q.delete();
  endtask

  task automatic test_ignored_cfg();
    int n;
    b.out_ready = 1'b1;
    b.cfg_we = 1'b1; b.cfg_addr = 8'h02; b.cfg_data = 1'b0; cycle();
    b.cfg_we = 1'b0;
    b.out_ready = 1'b0;
    b.in_valid = 1'b1; b.in_data = 8'h40; cycle();
    b.in_valid = 1'b0; b.cfg_start = 1'b1; cycle();
    b.cfg_start = 1'b0;
    b.cfg_we = 1'b1; b.cfg_addr = 8'h02; b.cfg_data = 1'b0; b.cfg_done = 1'b1; cycle();
    b.cfg_we = 1'b0; b.cfg_done = 1'b0;
    checks++; if (b.cfg_ready !== 1'b0) begin errors++; $display("FAIL ign_drain_cfg_ready: got %0b expected 0", b.cfg_ready); end
    b.out_ready = 1'b1;
    n = 0;
    while (b.cfg_ready !== 1'b1 && n < 10) begin cycle(); n++; end
    checks++; if (b.cfg_ready !== 1'b1) begin errors++; $display("FAIL ign_drain_timeout: cfg_ready got %0b expected 1", b.cfg_ready); end
    b.cfg_done = 1'b1; cycle();
    b.cfg_done = 1'b0;
    b.in_valid = 1'b1; b.in_data = 8'h02; cycle();
    b.in_valid = 1'b0; cycle();
    checks++; if (b.out_valid !== 1'b1) begin errors++; $display("FAIL ign_lookup_valid: got %0b expected 1", b.out_valid); end
    checks++; if (b.out_data !== 1'b1) begin errors++; $display("FAIL ign_lookup_data: got %0d expected 1", b.out_data); end
    cycle();
    got_q.delete();
    want_q.delete();
  endtask

  task automatic test_reset_midstream();
    b.out_ready = 1'b0;
    b.in_valid = 1'b1; b.in_data = 8'h02; cycle();
    b.in_data = 8'h40; cycle();
    b.in_valid = 1'b0;
    checks++; if (b.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %0b expected 1", b.out_valid); end
    rst = 1'b1; cycle();
    rst = 1'b0;
    checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %0b expected 0", b.out_valid); end
    checks++; if (b.cfg_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cfg_ready: got %0b expected 1", b.cfg_ready); end
    checks++; if (b.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %0b expected 0", b.in_ready); end
    got_q.delete();
    want_q.delete();
    b.out_ready = 1'b1;
    b.cfg_done = 1'b1; cycle();
    b.cfg_done = 1'b0;
    b.in_valid = 1'b1; b.in_data = 8'h40; cycle();
    b.in_data = 8'h02; cycle();
    b.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL rstmid_count: got %0d expected 2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] != 0) begin errors++; $display("FAIL rstmid_0x40: got %0d expected 0", got_q[0]); end
      checks++; if (got_q[1] != 1) begin errors++; $display("FAIL rstmid_0x02: got %0d expected 1", got_q[1]); end
    end
    got_q.delete();
    want_q.delete();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      b.in_valid  = $urandom_range(0, 1);
      b.in_data   = 8'($urandom_range(0, 255));
      b.out_ready = ($urandom_range(0, 3) != 0);
      b.cfg_we    = ($urandom_range(0, 2) == 0);
      b.cfg_addr  = 8'($urandom_range(0, 255));
      b.cfg_data  = 1'($urandom_range(0, 1));
      b.cfg_start = ($urandom_range(0, 24) == 0);
      b.cfg_done  = ($urandom_range(0, 5) == 0);
      #1;
      checks++; if (b.in_ready !== m_in_ready()) begin errors++; $display("FAIL rand_in_ready[%0d]: got %0b expected %0b", c, b.in_ready, m_in_ready()); end
      checks++; if (b.cfg_ready !== (mstate == 0)) begin errors++; $display("FAIL rand_cfg_ready[%0d]: got %0b expected %0b", c, b.cfg_ready, (mstate == 0)); end
      if (exp_q.size() == 0) begin
        checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL rand_idle_valid[%0d]: got %0b expected 0", c, b.out_valid); end
      end
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    b.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_undelivered: got %0d pending expected 0", exp_q.size()); end
    checks++; if (got_q.size() != want_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), want_q.size()); end
    for (int i = 0; i < got_q.size() && i < want_q.size(); i++) begin
      checks++; if (got_q[i] != want_q[i]) begin errors++; $display("FAIL rand_result[%0d]: got %0d expected %0d", i, got_q[i], want_q[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    b.out_ready = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_load();
    test_stream();
    test_backpressure();
    test_reload();
    test_ignored_cfg();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
